inst_rom: RTL and testbench
===========================

# inst_rom

Instruction memory for the RISCV core. It is the responder on the core's `rom_ce`/`rom_addr`/`rom_data` fetch port. After reset it accepts a byte-serial program image from a loader, packs the bytes little-endian into 32-bit words and writes them sequentially from word 0. Once the load completes it serves fetches with zero latency. `load_done_o` is used by the system top to hold the core in reset until the image is in place.

## Interface
- ADDR_WIDTH, 10, word-address width; depth = 2^ADDR_WIDTH words
- NOP_INST, 32'h00000013, value driven on `rom_data_o` whenever no valid fetch is served
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-low
- rom_ce_i  input  1  fetch enable from core
- rom_addr_i  input  32  byte address of fetch (core PC)
- rom_data_o  output  32  fetched instruction, combinational
- ld_valid_i  input  1  loader byte valid
- ld_data_i  input  8  loader byte
- ld_last_i  input  1  qualifies final byte of image (sampled with `ld_valid_i`)
- ld_ready_o  output  1  block accepts a loader byte this cycle
- load_done_o  output  1  image complete; fetch port live
- ld_err_o  output  1  sticky: image exceeded memory depth

## Operation
- States: LOAD, RUN. Reset enters LOAD. No other states.
- Internal: `wptr` (ADDR_WIDTH bits), `bcnt` (2 bits), `wbuf` (24 bits holding bytes 0..2 of the current word).
- LOAD:
  - `ld_ready_o`=1; a byte is accepted when `ld_valid_i`=1.
  - Byte k of a word (k=`bcnt`) occupies bits [8k+7:8k].
  - k<3: store in `wbuf`, `bcnt`++.
  - k=3: write {byte, wbuf} to mem[`wptr`], `wptr`++, `bcnt`=0.
  - Accepted byte with `ld_last_i`=1:
    - If the word is incomplete, write it with unfilled upper bytes = 0.
    - Go to RUN.
  - Overflow: a word write when `wptr` = 2^ADDR_WIDTH−1 and a prior write has already filled that slot does not happen. Instead, after the write to the last slot, set a `full` flag.
  - Any further accepted byte sets `ld_err_o` and is dropped; there is no wrap-around and word 0 is never overwritten.
  - `ld_last_i` still moves the block to RUN.
- RUN:
  - `ld_ready_o`=0; `ld_valid_i`/`ld_last_i` ignored.
  - Stays in RUN until reset.
- Fetch path, combinational:
  - If state=RUN, `rom_ce_i`=1 and `rom_addr_i[31:ADDR_WIDTH+2]`=0: `rom_data_o` = mem[`rom_addr_i[ADDR_WIDTH+1:2]`]. `rom_addr_i[1:0]` is ignored.
  - Otherwise `rom_data_o` = NOP_INST. This covers LOAD state, ce low, and out-of-range address.
- Memory array is not cleared by reset. Words never written read as X in simulation; the bench must not fetch them.

## Timing
- Reset values (any edge with `rst`=0):
  - state=LOAD, `wptr`=0, `bcnt`=0, `full`=0.
  - `ld_ready_o`=1, `load_done_o`=0, `ld_err_o`=0.
  - `rom_data_o`=NOP_INST.
- Byte accept: on the rising edge where `ld_valid_i`&&`ld_ready_o`.
- A word is written on the edge accepting its 4th byte, or its last byte. It is visible to the fetch path from the next cycle, subject to state=RUN.
- `load_done_o` rises on the cycle after the edge that accepts the `ld_last_i` byte, and `ld_ready_o` falls on the same cycle. `load_done_o` equals (state==RUN).
- `ld_err_o` rises on the cycle after the first dropped byte and holds until reset.
- Fetch latency: zero cycles. `rom_data_o` follows `rom_addr_i`/`rom_ce_i` in the same cycle, as the core's IF/ID register samples PC and data together.
- Reset mid-load:
  - Partial word in `wbuf` is discarded.
  - The next load restarts at word 0.
  - Previously written words persist until overwritten.
- Reset during RUN: returns to LOAD immediately on that edge. `rom_data_o` is NOP_INST from the next cycle.

## Test plan
- **Reset defaults:** hold `rst`=0 for 2 cycles, then release. Expect `ld_ready_o`=1, `load_done_o`=0, `ld_err_o`=0. With `rom_ce_i`=1 and addr 0, expect `rom_data_o`=32'h00000013.
- **Full-word load:**
  - Stimulus: stream bytes 93,00,10,00, 13,01,20,00, the last byte with `ld_last_i`.
  - Expect `load_done_o`=1 the next cycle.
  - Expect fetch addr 0 → 32'h00100093; addr 4 → 32'h00200113; addr 5 → 32'h00200113 (low bits ignored).
- **Partial final word:** load 6 bytes 11,22,33,44,55,66 with `ld_last_i` on the 6th. Expect addr 4 → 32'h00006655, and addr 0 → 32'h44332211.
- **Fetch gating in RUN:**
  - `rom_ce_i`=0 → NOP_INST.
  - Addr 32'h00001000 with ADDR_WIDTH=10 → NOP_INST.
  - Loader bytes offered in RUN → `ld_ready_o`=0 and memory unchanged.
- **Overflow:**
  - Setup: ADDR_WIDTH=2; stream 20 bytes, `ld_last_i` on the 20th.
  - Expect `ld_err_o`=1 after the 17th byte.
  - Expect word 0 to still hold bytes 0–3, word 3 to hold bytes 12–15, and `load_done_o`=1 after the 20th byte.
- **Reset mid-load:**
  - Stimulus: accept 6 bytes, assert `rst`=0 for 1 cycle, then load AA,BB,CC,DD with `ld_last_i`.
  - Expect addr 0 → 32'hDDCCBBAA and word 1 unchanged from the earlier write.
  - Also assert `rst`=0 during RUN and expect `rom_data_o`=NOP_INST the next cycle.

Source files
------------

// File: rtl/inst_rom.sv
// inst_rom: instruction memory for the RISCV core.
// After reset it packs a byte-serial program image (little-endian) into
// 32-bit words written sequentially from word 0, then serves zero-latency
// fetches on the rom_ce/rom_addr/rom_data port.
module inst_rom #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        load_done_o,
    output logic        ld_err_o
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] WPTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] wptr_r;
    logic [1:0]            bcnt_r;
    logic [23:0]           wbuf_r;
    logic                  full_r;
    logic                  ready_r;
    logic                  done_r;
    logic                  err_r;

    logic [31:0]           mem_r [0:DEPTH-1];

    logic                  accept_s;
    logic                  wr_en_s;
    logic [31:0]           wr_word_s;
    logic                  addr_in_range_s;
    logic                  unused_addr_s;

    // Build the word to store: new byte at lane k, earlier lanes from the
    // buffer, lanes above k forced to zero so a short final word is clean.
    function automatic logic [31:0] pack_word(input logic [1:0]  k,
                                              input logic [7:0]  b,
                                              input logic [23:0] wbuf);
        logic [31:0] w;
        case (k)
            2'd0:    w = {24'h000000, b};
            2'd1:    w = {16'h0000, b, wbuf[7:0]};
            2'd2:    w = {8'h00, b, wbuf[15:0]};
            2'd3:    w = {b, wbuf};
            default: w = {24'h000000, b};
        endcase
        return w;
    endfunction

    // Byte accept and word-write decode for the loader side.
    always_comb begin
        accept_s  = 1'b0;
        wr_en_s   = 1'b0;
        wr_word_s = pack_word(bcnt_r, ld_data_i, wbuf_r);
        if ((state_r == ST_LOAD) && ld_valid_i) begin
            accept_s = 1'b1;
            if (!full_r && ((bcnt_r == 2'd3) || ld_last_i)) begin
                wr_en_s = 1'b1;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
            wr_en_s  = 1'b0;
        end
    end

    // Program storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wptr_r] <= wr_word_s;
        end
    end

    // Load/run control: byte packing, write pointer, full/error tracking
    // and the registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_LOAD;
            wptr_r  <= '0;
            bcnt_r  <= 2'd0;
            wbuf_r  <= 24'h000000;
            full_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (full_r) begin
                            // Image larger than the array: drop, never wrap.
                            err_r <= 1'b1;
                        end else if (wr_en_s) begin
                            bcnt_r <= 2'd0;
                            if (wptr_r == LAST_SLOT) begin
                                full_r <= 1'b1;
                            end else begin
                                wptr_r <= wptr_r + WPTR_ONE;
                            end
                        end else begin
                            bcnt_r <= bcnt_r + 2'd1;
                            case (bcnt_r)
                                2'd0:    wbuf_r[7:0]   <= ld_data_i;
                                2'd1:    wbuf_r[15:8]  <= ld_data_i;
                                2'd2:    wbuf_r[23:16] <= ld_data_i;
                                default: wbuf_r        <= wbuf_r;
                            endcase
                        end
                        if (ld_last_i) begin
                            state_r <= ST_RUN;
                            ready_r <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    ready_r <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_LOAD;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_in_range_s = (rom_addr_i[31:ADDR_WIDTH+2] == '0);
    assign unused_addr_s   = ^rom_addr_i[1:0];

    // Zero-latency fetch: NOP unless running, enabled and in range.
    always_comb begin
        rom_data_o = NOP_INST;
        if ((state_r == ST_RUN) && rom_ce_i && addr_in_range_s) begin
            rom_data_o = mem_r[rom_addr_i[ADDR_WIDTH+1:2]];
        end else begin
            rom_data_o = NOP_INST;
        end
    end

    assign ld_ready_o  = ready_r;
    assign load_done_o = done_r;
    assign ld_err_o    = err_r;

endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench for inst_rom: a default-size instance for load/fetch
// behaviour and an ADDR_WIDTH=2 instance for the overflow case.
module tb_inst_rom;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ce_a = 1'b0, ld_valid_a = 1'b0, ld_last_a = 1'b0;
    logic [31:0] addr_a = 32'h0;
    logic [7:0]  ld_data_a = 8'h00;
    logic [31:0] data_a;
    logic        ready_a, done_a, err_a;

    logic        ce_b = 1'b0, ld_valid_b = 1'b0, ld_last_b = 1'b0;
    logic [31:0] addr_b = 32'h0;
    logic [7:0]  ld_data_b = 8'h00;
    logic [31:0] data_b;
    logic        ready_b, done_b, err_b;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } fvec_t;

    fvec_t vecs [0:9];

    inst_rom #(.ADDR_WIDTH(10), .NOP_INST(32'h00000013)) dut_a (
        .clk(clk), .rst(rst),
        .rom_ce_i(ce_a), .rom_addr_i(addr_a), .rom_data_o(data_a),
        .ld_valid_i(ld_valid_a), .ld_data_i(ld_data_a), .ld_last_i(ld_last_a),
        .ld_ready_o(ready_a), .load_done_o(done_a), .ld_err_o(err_a)
    );

    inst_rom #(.ADDR_WIDTH(2), .NOP_INST(32'h00000013)) dut_b (
        .clk(clk), .rst(rst),
        .rom_ce_i(ce_b), .rom_addr_i(addr_b), .rom_data_o(data_b),
        .ld_valid_i(ld_valid_b), .ld_data_i(ld_data_b), .ld_last_i(ld_last_b),
        .ld_ready_o(ready_b), .load_done_o(done_b), .ld_err_o(err_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive a fetch, queue its expectation, compare at the falling edge.
    task automatic fetch(input bit sel_b, input logic ce, input logic [31:0] addr,
                         input logic [31:0] exp, input string name);
        logic [31:0] e;
        if (sel_b) begin ce_b = ce; addr_b = addr; end
        else       begin ce_a = ce; addr_a = addr; end
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, sel_b ? data_b : data_a, e);
    endtask

    task automatic send_a(input logic [7:0] b, input logic last);
        ld_valid_a = 1'b1; ld_data_a = b; ld_last_a = last;
        @(posedge clk); #1;
        ld_valid_a = 1'b0; ld_last_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, input logic last);
        ld_valid_b = 1'b1; ld_data_b = b; ld_last_b = last;
        @(posedge clk); #1;
        ld_valid_b = 1'b0; ld_last_b = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        // Fetch table after loading 93 00 10 00 13 01 20 00
        vecs[0] = '{ce: 1'b1, addr: 32'h00000000, exp: 32'h00100093};
        vecs[1] = '{ce: 1'b1, addr: 32'h00000004, exp: 32'h00200113};
        vecs[2] = '{ce: 1'b1, addr: 32'h00000005, exp: 32'h00200113};
        vecs[3] = '{ce: 1'b1, addr: 32'h00000007, exp: 32'h00200113};
        vecs[4] = '{ce: 1'b1, addr: 32'h00000003, exp: 32'h00100093};
        vecs[5] = '{ce: 1'b0, addr: 32'h00000000, exp: NOP};
        vecs[6] = '{ce: 1'b0, addr: 32'h00000004, exp: NOP};
        vecs[7] = '{ce: 1'b1, addr: 32'h00001000, exp: NOP};
        vecs[8] = '{ce: 1'b1, addr: 32'h80000004, exp: NOP};
        vecs[9] = '{ce: 1'b1, addr: 32'h00001004, exp: NOP};

        // Reset defaults
        do_reset(2);
        @(negedge clk);
        check("rst_ready", {31'h0, ready_a}, 32'h1);
        check("rst_done", {31'h0, done_a}, 32'h0);
        check("rst_err", {31'h0, err_a}, 32'h0);
        check("rst_ready_b", {31'h0, ready_b}, 32'h1);
        fetch(1'b0, 1'b1, 32'h0, NOP, "rst_fetch");

        // Full-word load
        send_a(8'h93, 1'b0); send_a(8'h00, 1'b0); send_a(8'h10, 1'b0); send_a(8'h00, 1'b0);
        fetch(1'b0, 1'b1, 32'h0, NOP, "load_state_fetch");
        send_a(8'h13, 1'b0); send_a(8'h01, 1'b0); send_a(8'h20, 1'b0);
        check("pre_last_done", {31'h0, done_a}, 32'h0);
        send_a(8'h00, 1'b1);
        @(negedge clk);
        check("done_after_last", {31'h0, done_a}, 32'h1);
        check("ready_after_last", {31'h0, ready_a}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            fetch(1'b0, vecs[i].ce, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Loader bytes offered in RUN are refused and ignored
        ld_valid_a = 1'b1; ld_data_a = 8'hEE; ld_last_a = 1'b1;
        @(negedge clk);
        check("run_ready", {31'h0, ready_a}, 32'h0);
        repeat (2) @(posedge clk);
        #1 ld_valid_a = 1'b0; ld_last_a = 1'b0;
        fetch(1'b0, 1'b1, 32'h0, 32'h00100093, "run_mem_w0");
        fetch(1'b0, 1'b1, 32'h4, 32'h00200113, "run_mem_w1");

        // Partial final word
        do_reset(1);
        send_a(8'h11, 1'b0); send_a(8'h22, 1'b0); send_a(8'h33, 1'b0);
        send_a(8'h44, 1'b0); send_a(8'h55, 1'b0); send_a(8'h66, 1'b1);
        fetch(1'b0, 1'b1, 32'h4, 32'h00006655, "partial_w1");
        fetch(1'b0, 1'b1, 32'h0, 32'h44332211, "partial_w0");

        // Reset mid-load: partial word discarded, restart at word 0
        do_reset(1);
        send_a(8'h01, 1'b0); send_a(8'h02, 1'b0); send_a(8'h03, 1'b0);
        send_a(8'h04, 1'b0); send_a(8'h05, 1'b0); send_a(8'h06, 1'b0);
        @(negedge clk);
        check("midload_ready", {31'h0, ready_a}, 32'h1);
        do_reset(1);
        send_a(8'hAA, 1'b0); send_a(8'hBB, 1'b0); send_a(8'hCC, 1'b0); send_a(8'hDD, 1'b1);
        fetch(1'b0, 1'b1, 32'h0, 32'hDDCCBBAA, "reload_w0");
        fetch(1'b0, 1'b1, 32'h4, 32'h00006655, "reload_w1_kept");

        // Reset during RUN
        ce_a = 1'b1; addr_a = 32'h0;
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        fetch(1'b0, 1'b1, 32'h0, NOP, "run_reset_nop");
        check("run_reset_done", {31'h0, done_a}, 32'h0);
        check("run_reset_ready", {31'h0, ready_a}, 32'h1);

        // Overflow on the 4-word instance: bytes 1..20, last on the 20th
        for (int i = 1; i <= 16; i++) begin
            send_b(i[7:0], 1'b0);
        end
        @(negedge clk);
        check("ovf_err_16", {31'h0, err_b}, 32'h0);
        send_b(8'd17, 1'b0);
        @(negedge clk);
        check("ovf_err_17", {31'h0, err_b}, 32'h1);
        check("ovf_ready_17", {31'h0, ready_b}, 32'h1);
        send_b(8'd18, 1'b0); send_b(8'd19, 1'b0); send_b(8'd20, 1'b1);
        @(negedge clk);
        check("ovf_done", {31'h0, done_b}, 32'h1);
        check("ovf_err_hold", {31'h0, err_b}, 32'h1);
        fetch(1'b1, 1'b1, 32'h0,  32'h04030201, "ovf_w0");
        fetch(1'b1, 1'b1, 32'h4,  32'h08070605, "ovf_w1");
        fetch(1'b1, 1'b1, 32'hC,  32'h100F0E0D, "ovf_w3");
        fetch(1'b1, 1'b1, 32'h10, NOP,          "ovf_out_of_range");

        if (exp_q.size() != 0) begin
            check("queue_empty", exp_q.size(), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
